// File: rtl/gr_wb_sel.sv
// gr_wb_sel: write-back source select with load extension and a one-entry output register.
//
// Selects one of NSRC write-back sources. The memory data source (EXT_SRC) can be
// byte- or halfword-extended. The result is registered for the GR file write port.
// A registered entry is held while the GR file stalls.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   sel       : source index; indices >= NSRC select zero
//   src_data  : flattened sources, source i at [i*DW +: DW]
//   wb_req    : write-back request
//   wb_addr   : destination GR
//   ext_mode  : 00 word, 01 byte, 10 halfword, 11 word
//   ext_sign  : 1 sign-extend, 0 zero-extend
//   byte_off  : low address bits of the load
//   stall     : GR file cannot take a write this cycle
//   wb_ready  : request accepted this cycle when wb_req is high
//   gr_we     : GR write enable, suppressed for GR 0
//   gr_waddr  : GR write address
//   gr_wdata  : GR write data
//   misalign  : one-cycle flag for a halfword load with byte_off[0] set
module gr_wb_sel #(
    parameter int unsigned DW      = 32,
    parameter int unsigned NSRC    = 8,
    parameter int unsigned SELW    = 3,
    parameter int unsigned EXT_SRC = 1,
    parameter int unsigned AW      = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SELW-1:0]    sel,
    input  logic [NSRC*DW-1:0] src_data,
    input  logic               wb_req,
    input  logic [AW-1:0]      wb_addr,
    input  logic [1:0]         ext_mode,
    input  logic               ext_sign,
    input  logic [1:0]         byte_off,
    input  logic               stall,
    output logic               wb_ready,
    output logic               gr_we,
    output logic [AW-1:0]      gr_waddr,
    output logic [DW-1:0]      gr_wdata,
    output logic               misalign
);

    typedef enum logic {StIdle, StFull} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          mis_q, mis_d;

    logic          valid;
    logic          accept;
    logic          consume;
    logic          is_ext;
    logic [31:0]   sel_ext;
    logic [DW-1:0] src_sel;
    logic [7:0]    byte_lane;
    logic [15:0]   half_lane;
    logic [DW-1:0] ext_data;

    assign valid    = (state_q == StFull);
    assign wb_ready = !valid || !stall;
    assign accept   = wb_req && wb_ready;
    assign consume  = valid && !stall;
    assign sel_ext  = 32'(sel);
    assign is_ext   = (sel_ext == EXT_SRC);

    // Source mux; out-of-range indices fall through to zero.
    always_comb begin
        src_sel = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (sel_ext == i) begin
                src_sel = src_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        byte_lane = 8'h00;
        unique case (byte_off)
            2'd0: byte_lane = src_sel[7:0];
            2'd1: byte_lane = src_sel[15:8];
            2'd2: byte_lane = src_sel[23:16];
            2'd3: byte_lane = src_sel[31:24];
            default: byte_lane = 8'h00;
        endcase
    end

    // Halfword lane ignores byte_off[0]; a misaligned halfword still writes.
    assign half_lane = byte_off[1] ? src_sel[31:16] : src_sel[15:0];

    always_comb begin
        ext_data = src_sel;
        if (is_ext) begin
            case (ext_mode)
                2'b01:   ext_data = {{(DW-8){ext_sign & byte_lane[7]}}, byte_lane};
                2'b10:   ext_data = {{(DW-16){ext_sign & half_lane[15]}}, half_lane};
                default: ext_data = src_sel;
            endcase
        end
    end

    // Accept has priority: with a same-cycle consume the new entry replaces the old.
    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        mis_d   = 1'b0;
        if (accept) begin
            state_d = StFull;
            waddr_d = wb_addr;
            wdata_d = ext_data;
            mis_d   = is_ext && (ext_mode == 2'b10) && byte_off[0];
        end else if (consume) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            waddr_q <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
        end
    end

    // Entries for GR 0 are drained without a write.
    assign gr_we    = consume && (waddr_q != '0);
    assign gr_waddr = waddr_q;
    assign gr_wdata = wdata_q;
    assign misalign = mis_q;

endmodule

// File: tb/tb_gr_wb_sel.sv
module tb_gr_wb_sel;

    localparam int unsigned DW      = 32;
    localparam int unsigned NSRC    = 7;
    localparam int unsigned SELW    = 3;
    localparam int unsigned EXT_SRC = 1;
    localparam int unsigned AW      = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [SELW-1:0]    sel;
    logic [NSRC*DW-1:0] src_data;
    logic               wb_req;
    logic [AW-1:0]      wb_addr;
    logic [1:0]         ext_mode;
    logic               ext_sign;
    logic [1:0]         byte_off;
    logic               stall;
    logic               wb_ready;
    logic               gr_we;
    logic [AW-1:0]      gr_waddr;
    logic [DW-1:0]      gr_wdata;
    logic               misalign;

    gr_wb_sel #(
        .DW      (DW),
        .NSRC    (NSRC),
        .SELW    (SELW),
        .EXT_SRC (EXT_SRC),
        .AW      (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .src_data (src_data),
        .wb_req   (wb_req),
        .wb_addr  (wb_addr),
        .ext_mode (ext_mode),
        .ext_sign (ext_sign),
        .byte_off (byte_off),
        .stall    (stall),
        .wb_ready (wb_ready),
        .gr_we    (gr_we),
        .gr_waddr (gr_waddr),
        .gr_wdata (gr_wdata),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Expected write data straight from the selection and extension rules.
    function automatic logic [DW-1:0] exp_data(input int unsigned s,
                                               input logic [NSRC*DW-1:0] src,
                                               input logic [1:0] mode, input logic sg,
                                               input logic [1:0] off);
        longint unsigned v, lane, full;
        full = 64'd1 << DW;
        if (s >= NSRC) return '0;
        v = 64'(src >> (s * DW)) & (full - 1);
        if (s != EXT_SRC) return v[DW-1:0];
        if (mode == 2'b01) begin
            lane = (v >> (8 * off)) % 256;
            if (sg && lane >= 128) lane = lane + full - 256;
        end else if (mode == 2'b10) begin
            lane = (v >> (16 * (off / 2))) % 65536;
            if (sg && lane >= 32768) lane = lane + full - 65536;
        end else begin
            lane = v;
        end
        return lane[DW-1:0];
    endfunction

    // Reference: one-entry register seen as (valid, addr, data, misalign flag).
    bit            m_valid = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;
    bit            m_mis   = 1'b0;

    always @(posedge clk) begin
        bit ready, acc;
        if (rst) begin
            m_valid = 1'b0;
            m_addr  = '0;
            m_data  = '0;
            m_mis   = 1'b0;
        end else begin
            ready = !m_valid || !stall;
            acc   = wb_req && ready;
            if (acc) begin
                m_valid = 1'b1;
                m_addr  = wb_addr;
                m_data  = exp_data(32'(sel), src_data, ext_mode, ext_sign, byte_off);
                m_mis   = (32'(sel) == EXT_SRC) && ext_mode == 2'b10 && byte_off[0];
            end else begin
                m_mis = 1'b0;
                if (m_valid && !stall) m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_wb_ready", 64'(wb_ready), 64'(!m_valid || !stall));
            check("m_gr_we", 64'(gr_we), 64'(m_valid && !stall && m_addr != 0));
            check("m_misalign", 64'(misalign), 64'(m_mis));
            if (m_valid) begin
                check("m_gr_waddr", 64'(gr_waddr), 64'(m_addr));
                check("m_gr_wdata", 64'(gr_wdata), 64'(m_data));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int unsigned i, input logic [DW-1:0] v);
        src_data[i*DW +: DW] = v;
    endtask

    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        check(name, act, exp);
    endtask

    initial begin
        rst = 1'b1; sel = '0; src_data = '0; wb_req = 1'b0; wb_addr = '0;
        ext_mode = 2'b00; ext_sign = 1'b0; byte_off = 2'b00; stall = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        lit("rst_wb_ready", 64'(wb_ready), 64'd1);
        lit("rst_gr_we", 64'(gr_we), 64'd0);
        lit("rst_gr_waddr", 64'(gr_waddr), 64'd0);
        lit("rst_gr_wdata", 64'(gr_wdata), 64'd0);
        lit("rst_misalign", 64'(misalign), 64'd0);

        // Plain word write.
        cyc();
        sel = 3'd0; set_src(0, 32'h12345678); wb_addr = 5'd3; wb_req = 1'b1;
        cyc();
        wb_req = 1'b0;
        @(negedge clk);
        lit("word_we", 64'(gr_we), 64'd1);
        lit("word_addr", 64'(gr_waddr), 64'd3);
        lit("word_data", 64'(gr_wdata), 64'h12345678);

        // Byte extension, back-to-back.
        cyc();
        sel = 3'd1; set_src(1, 32'h80FF7F01); ext_mode = 2'b01; byte_off = 2'd2;
        ext_sign = 1'b1; wb_addr = 5'd4; wb_req = 1'b1;
        cyc();
        ext_sign = 1'b0;
        @(negedge clk);
        lit("byte2_signed", 64'(gr_wdata), 64'hFFFFFFFF);
        cyc();
        byte_off = 2'd0; ext_sign = 1'b1;
        @(negedge clk);
        lit("byte2_zero", 64'(gr_wdata), 64'h000000FF);
        cyc();
        wb_req = 1'b0;
        @(negedge clk);
        lit("byte0_signed", 64'(gr_wdata), 64'h00000001);

        // Misaligned signed halfword.
        cyc();
        ext_mode = 2'b10; byte_off = 2'd3; ext_sign = 1'b1; wb_req = 1'b1;
        cyc();
        wb_req = 1'b0;
        @(negedge clk);
        lit("half3_data", 64'(gr_wdata), 64'hFFFF80FF);
        lit("half3_mis", 64'(misalign), 64'd1);
        lit("half3_we", 64'(gr_we), 64'd1);
        cyc();
        @(negedge clk);
        lit("half3_mis_drop", 64'(misalign), 64'd0);

        // Stall holds the entry; drop of stall drains and accepts in one cycle.
        cyc();
        ext_mode = 2'b00; sel = 3'd0; set_src(0, 32'hAAAA5555); wb_addr = 5'd5; wb_req = 1'b1;
        cyc();
        stall = 1'b1; set_src(0, 32'h0BADCAFE); wb_addr = 5'd6;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            lit("stall_we", 64'(gr_we), 64'd0);
            lit("stall_ready", 64'(wb_ready), 64'd0);
            lit("stall_addr", 64'(gr_waddr), 64'd5);
            lit("stall_data", 64'(gr_wdata), 64'hAAAA5555);
            cyc();
        end
        stall = 1'b0;
        @(negedge clk);
        lit("drain1_we", 64'(gr_we), 64'd1);
        lit("drain1_addr", 64'(gr_waddr), 64'd5);
        lit("drain1_ready", 64'(wb_ready), 64'd1);
        cyc();
        wb_req = 1'b0;
        @(negedge clk);
        lit("drain2_we", 64'(gr_we), 64'd1);
        lit("drain2_addr", 64'(gr_waddr), 64'd6);
        lit("drain2_data", 64'(gr_wdata), 64'h0BADCAFE);

        // GR 0 drains silently; out-of-range select gives zero.
        cyc();
        wb_addr = 5'd0; wb_req = 1'b1;
        cyc();
        wb_req = 1'b0;
        @(negedge clk);
        lit("gr0_we", 64'(gr_we), 64'd0);
        cyc();
        stall = 1'b1;
        @(negedge clk);
        lit("gr0_cleared", 64'(wb_ready), 64'd1);
        cyc();
        stall = 1'b0; sel = 3'd7; wb_addr = 5'd9; wb_req = 1'b1;
        cyc();
        wb_req = 1'b0;
        @(negedge clk);
        lit("sel7_we", 64'(gr_we), 64'd1);
        lit("sel7_data", 64'(gr_wdata), 64'd0);

        // Reset while holding a stalled entry.
        cyc();
        sel = 3'd0; wb_addr = 5'd10; wb_req = 1'b1;
        cyc();
        stall = 1'b1; wb_req = 1'b0;
        @(negedge clk);
        lit("pre_rst_we", 64'(gr_we), 64'd0);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        lit("post_rst_we", 64'(gr_we), 64'd0);
        lit("post_rst_addr", 64'(gr_waddr), 64'd0);
        lit("post_rst_data", 64'(gr_wdata), 64'd0);
        lit("post_rst_ready", 64'(wb_ready), 64'd1);

        // Randomized traffic against the reference.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst      = ($urandom_range(0, 63) == 0);
            stall    = ($urandom_range(0, 2) == 0);
            wb_req   = ($urandom_range(0, 3) != 0);
            sel      = ($urandom_range(0, 1) == 0) ? SELW'(EXT_SRC) : SELW'($urandom_range(0, 7));
            wb_addr  = AW'($urandom);
            ext_mode = 2'($urandom);
            ext_sign = 1'($urandom);
            byte_off = 2'($urandom);
            for (int i = 0; i < int'(NSRC); i++) set_src(i, DW'($urandom));
        end
        cyc();
        rst = 1'b0; wb_req = 1'b0; stall = 1'b0;
        cyc(); cyc();
        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
